ram_byte_loader: RTL and testbench

//  Client-side stage that streams a program image from a byte source (UART receiver)

---
 rtl/pkg_loader.sv | 14 +
 rtl/pkg_ram.sv | 19 +
 rtl/if_ram.sv | 15 +
 rtl/ram_loader_hdr_shift.sv | 45 ++++
 rtl/ram_byte_loader.sv | 167 ++++++++++++++++
 tb/tb_ram_byte_loader.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/pkg_loader.sv
// Byte-loader definitions: FSM state encoding shared by the loader and its bench.
package pkg_loader;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/pkg_ram.sv
// Shared RAM bus definitions: operation codes, access widths and bus geometry.
package pkg_ram;

    localparam int RAM_ADDRW     = 10;
    localparam int RAM_QUAD_SIZE = 32;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } data_type_t;

endpackage

// File: rtl/if_ram.sv
// RAM access bus. Clients drive a request every cycle (NOP when idle); the server
// returns read data on data_out.
interface if_ram;
    import pkg_ram::*;

    op_t                      op;
    data_type_t               data_type;
    logic [RAM_ADDRW-1:0]     addr;
    logic [RAM_QUAD_SIZE-1:0] data_in;
    logic [RAM_QUAD_SIZE-1:0] data_out;

    modport client (output op, output data_type, output addr, output data_in, input data_out);
    modport server (input op, input data_type, input addr, input data_in, output data_out);

endinterface

// File: rtl/ram_loader_hdr_shift.sv
// N-byte header field collector. Bytes enter at the LSB end so the first byte
// received ends up as the MSB. 'shifted' is the value the register would hold if
// byte_in were taken this cycle, letting the owner act on a complete field in the
// same cycle its last byte arrives.
module ram_loader_hdr_shift #(
    parameter int N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [8*N_BYTES-1:0]   value,
    output logic [8*N_BYTES-1:0]   shifted,
    output logic                   last,
    output logic                   full
);

    localparam int W  = 8 * N_BYTES;
    localparam int CW = $clog2(N_BYTES + 1);

    logic [CW-1:0] count;

    // Next-value view and counter flags.
    always_comb begin
        shifted = (value << 8) | W'(byte_in);
        last    = (count == CW'(N_BYTES - 1));
        full    = (count == CW'(N_BYTES));
    end

    // Shift in accepted bytes until the field is full; clear re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (shift_en && !full) begin
            value <= shifted;
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ram_byte_loader.sv
// Streams a framed program image (addr, len, data bytes, checksum) from a byte
// source into RAM as byte stores.
// Byte handshake: a byte transfers on any rising clk edge where rx_valid && rx_ready;
// rx_ready depends only on the FSM state, never on rx_valid.
module ram_byte_loader
    import pkg_ram::*;
    import pkg_loader::*;
#(
    parameter int ADDR_BYTES = 4,
    parameter int LEN_BYTES  = 4,
    parameter int RAM_BYTES  = 2 ** RAM_ADDRW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    if_ram.client                ram,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [RAM_ADDRW-1:0] entry_addr,
    output loader_state_t        state
);

    localparam int AW    = 8 * ADDR_BYTES;
    localparam int LW    = 8 * LEN_BYTES;
    localparam int SUM_W = ((AW > LW) ? AW : LW) + 1;

    logic                     accept;
    logic                     start_ok;
    logic [AW-1:0]            addr_val;
    logic [AW-1:0]            addr_shifted;
    logic                     addr_last;
    logic                     addr_full;
    logic [LW-1:0]            len_val;
    logic [LW-1:0]            len_shifted;
    logic                     len_last;
    logic                     len_full;
    logic [SUM_W-1:0]         span_end;
    logic                     bounds_bad;
    logic [RAM_ADDRW-1:0]     cur_addr;
    logic [LW-1:0]            remaining;
    logic [7:0]               sum;
    op_t                      op_q;
    logic [RAM_ADDRW-1:0]     addr_q;
    logic [RAM_QUAD_SIZE-1:0] data_q;

    ram_loader_hdr_shift #(.N_BYTES(ADDR_BYTES)) u_addr_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .shift_en (accept && (state == ADDR)),
        .byte_in  (rx_data),
        .value    (addr_val),
        .shifted  (addr_shifted),
        .last     (addr_last),
        .full     (addr_full)
    );

    ram_loader_hdr_shift #(.N_BYTES(LEN_BYTES)) u_len_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .shift_en (accept && (state == LEN)),
        .byte_in  (rx_data),
        .value    (len_val),
        .shifted  (len_shifted),
        .last     (len_last),
        .full     (len_full)
    );

    // Handshake, status and the bounds check on the length as it completes.
    // The full header address (including bits above RAM_ADDRW) takes part in the
    // sum, which is one bit wider than either field so it never wraps.
    always_comb begin
        rx_ready   = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);
        busy       = rx_ready;
        accept     = rx_valid && rx_ready;
        start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
        span_end   = SUM_W'(addr_val) + SUM_W'(len_shifted);
        bounds_bad = (span_end > SUM_W'(RAM_BYTES));
    end

    // RAM request is registered; data_type is always a byte access.
    assign ram.op        = op_q;
    assign ram.data_type = BYTE;
    assign ram.addr      = addr_q;
    assign ram.data_in   = data_q;

    // Loader FSM, data counters, running checksum and the one-cycle store pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            entry_addr <= '0;
            cur_addr   <= '0;
            remaining  <= '0;
            sum        <= '0;
            op_q       <= NOP;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            op_q <= NOP;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_ok) begin
                        state     <= ADDR;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        sum       <= '0;
                        remaining <= '0;
                        cur_addr  <= '0;
                    end
                end
                ADDR: begin
                    if (accept && addr_last) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (accept && len_last) begin
                        entry_addr <= addr_val[RAM_ADDRW-1:0];
                        cur_addr   <= addr_val[RAM_ADDRW-1:0];
                        remaining  <= len_shifted;
                        if (bounds_bad) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (len_shifted == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        op_q      <= STORE;
                        addr_q    <= cur_addr;
                        data_q    <= {{(RAM_QUAD_SIZE-8){1'b0}}, rx_data};
                        cur_addr  <= cur_addr + RAM_ADDRW'(1);
                        remaining <= remaining - LW'(1);
                        sum       <= sum + rx_data;
                        if (remaining == LW'(1)) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == sum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_byte_loader.sv
// Directed bench for ram_byte_loader: a table of images with hand-computed outcomes,
// plus hand-written reset-abort and reload sequences.
module tb_ram_byte_loader;
    import pkg_ram::*;
    import pkg_loader::*;

    localparam int SW = RAM_ADDRW + RAM_QUAD_SIZE;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [RAM_ADDRW-1:0] entry_addr;
    loader_state_t        state_dbg;

    if_ram ram_if ();
    assign ram_if.data_out = '0;

    ram_byte_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram        (ram_if),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .entry_addr (entry_addr),
        .state      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] got_q[$];
    int            cyc_q[$];

    // Capture every store seen on the bus, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && ram_if.op == STORE) begin
            got_q.push_back({ram_if.addr, ram_if.data_in});
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] data;   // up to 4 bytes, first byte in [31:24]
        logic [7:0]  csum;
        int          gap_max;
        bit          poke;   // pulse start after the first data byte
        bit          exp_done;
        bit          exp_err;
        bit          exp_bounds;
    } vec_t;

    vec_t vecs[9];

    task automatic set_vec(input int k, input logic [31:0] a, input logic [31:0] l,
                           input logic [31:0] d, input logic [7:0] c, input int g,
                           input bit p, input bit ed, input bit ee, input bit eb);
        vecs[k].addr = a; vecs[k].len = l; vecs[k].data = d; vecs[k].csum = c;
        vecs[k].gap_max = g; vecs[k].poke = p;
        vecs[k].exp_done = ed; vecs[k].exp_err = ee; vecs[k].exp_bounds = eb;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_header(input vec_t v);
        for (int i = 0; i < 4; i++) send_byte(v.addr[31-8*i -: 8], v.gap_max);
        for (int i = 0; i < 4; i++) send_byte(v.len[31-8*i -: 8], v.gap_max);
    endtask

    task automatic run_load(input int k);
        vec_t v;
        v = vecs[k];
        exp_q.delete();
        got_q.delete();
        cyc_q.delete();
        if (!v.exp_bounds) begin
            for (int i = 0; i < int'(v.len); i++) begin
                exp_q.push_back({v.addr[RAM_ADDRW-1:0] + RAM_ADDRW'(i),
                                 {(RAM_QUAD_SIZE-8){1'b0}}, v.data[31-8*i -: 8]});
            end
        end
        pulse_start();
        check($sformatf("v%0d busy_after_start", k), 64'(busy), 64'd1);
        check($sformatf("v%0d done_cleared", k), 64'(done), 64'd0);
        check($sformatf("v%0d err_cleared", k), 64'(err), 64'd0);
        send_header(v);
        if (v.exp_bounds) begin
            check($sformatf("v%0d bounds_err", k), 64'(err), 64'd1);
            check($sformatf("v%0d bounds_done", k), 64'(done), 64'd0);
            check($sformatf("v%0d bounds_rx_ready", k), 64'(rx_ready), 64'd0);
        end else begin
            for (int i = 0; i < int'(v.len); i++) begin
                send_byte(v.data[31-8*i -: 8], v.gap_max);
                if (v.poke && i == 0) begin
                    pulse_start();
                    check($sformatf("v%0d start_ignored_state", k), 64'(state_dbg), 64'(DATA));
                end
            end
            send_byte(v.csum, v.gap_max);
            check($sformatf("v%0d done", k), 64'(done), 64'(v.exp_done));
            check($sformatf("v%0d err", k), 64'(err), 64'(v.exp_err));
            check($sformatf("v%0d rx_ready_end", k), 64'(rx_ready), 64'd0);
            if (v.exp_done)
                check($sformatf("v%0d entry_addr", k), 64'(entry_addr), 64'(v.addr[RAM_ADDRW-1:0]));
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d store_count", k), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("v%0d store%0d", k, i), 64'(got_q[i]), 64'(exp_q[i]));
        if (v.gap_max == 0 && !v.poke) begin
            for (int i = 1; i < cyc_q.size(); i++)
                check($sformatf("v%0d store%0d_back_to_back", k, i), 64'(cyc_q[i] - cyc_q[i-1]), 64'd1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;

        set_vec(0, 32'h0000_0100, 32'd3, 32'h1122_3300, 8'h66, 0, 0, 1, 0, 0);
        set_vec(1, 32'h0000_0100, 32'd3, 32'h1122_3300, 8'h67, 0, 0, 0, 1, 0);
        set_vec(2, 32'h0000_0200, 32'd0, 32'h0000_0000, 8'h00, 0, 0, 1, 0, 0);
        set_vec(3, 32'h0000_0100, 32'd3, 32'h1122_3300, 8'h66, 5, 0, 1, 0, 0);
        set_vec(4, 32'h0000_03FE, 32'd3, 32'h1122_3300, 8'h66, 0, 0, 0, 1, 1);
        set_vec(5, 32'h0000_03FD, 32'd3, 32'h0102_0300, 8'h06, 0, 0, 1, 0, 0);
        set_vec(6, 32'h8000_0000, 32'd1, 32'hAA00_0000, 8'hAA, 0, 0, 0, 1, 1);
        set_vec(7, 32'h0000_0010, 32'd2, 32'hFF02_0000, 8'h01, 0, 0, 1, 0, 0);
        set_vec(8, 32'h0000_0100, 32'd3, 32'h1122_3300, 8'h66, 0, 1, 1, 0, 0);

        repeat (2) @(negedge clk);
        check("reset state", 64'(state_dbg), 64'(IDLE));
        check("reset rx_ready", 64'(rx_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset entry_addr", 64'(entry_addr), 64'd0);
        check("reset op", 64'(ram_if.op), 64'(NOP));
        check("reset data_type", 64'(ram_if.data_type), 64'(BYTE));
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_load(k);

        // Abort a load with reset right after the second data byte.
        pulse_start();
        send_header(vecs[0]);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort op", 64'(ram_if.op), 64'(NOP));
        check("abort addr", 64'(ram_if.addr), 64'd0);
        check("abort data_in", 64'(ram_if.data_in), 64'd0);
        check("abort data_type", 64'(ram_if.data_type), 64'(BYTE));
        check("abort rx_ready", 64'(rx_ready), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort err", 64'(err), 64'd0);
        check("abort entry_addr", 64'(entry_addr), 64'd0);
        check("abort state", 64'(state_dbg), 64'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_load(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
